// File: rtl/pfu_pkg.sv
// Core constants shared by the prefetch unit and the vectoring block.
// Holds the reset vector, the instruction width and the bus error encoding.
package pfu_pkg;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int          C_INSN_W  = 32;

    typedef enum logic {
        BUS_OK  = 1'b0,
        BUS_ERR = 1'b1
    } bus_err_e;

endpackage

// File: rtl/pfu_if.sv
// Instruction-bus and decode-stage signals of the prefetch unit.
// The master modport is the prefetch unit; the slave side is the bus plus the decoder.
interface pfu_if #(
    parameter int C_XLEN = 32
);
    import pfu_pkg::*;

    logic                ireqready_i;
    logic                ireqvalid_o;
    logic [C_XLEN-1:0]   ireqaddr_o;
    logic                irspvalid_i;
    logic [C_INSN_W-1:0] irspdata_i;
    logic                irsprerr_i;
    logic                ids_dav_o;
    logic                ids_ack_i;
    logic [C_INSN_W-1:0] ids_ins_o;
    logic [C_XLEN-1:0]   ids_pc_o;
    logic                ids_ferr_o;

    modport master (
        input  ireqready_i, irspvalid_i, irspdata_i, irsprerr_i, ids_ack_i,
        output ireqvalid_o, ireqaddr_o, ids_dav_o, ids_ins_o, ids_pc_o, ids_ferr_o
    );

    modport slave (
        output ireqready_i, irspvalid_i, irspdata_i, irsprerr_i, ids_ack_i,
        input  ireqvalid_o, ireqaddr_o, ids_dav_o, ids_ins_o, ids_pc_o, ids_ferr_o
    );

endinterface

// File: rtl/pfu_fifo.sv
// Synchronous instruction buffer with flush, occupancy count and first-word fall-through head.
// Depth must be a power of two so the pointers wrap naturally.
module pfu_fifo #(
    parameter int C_DEPTH = 4,
    parameter int C_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_wr,
    input  logic [C_WIDTH-1:0]       i_wdata,
    input  logic                     i_rd,
    output logic [C_WIDTH-1:0]       o_rdata,
    output logic                     o_empty,
    output logic [$clog2(C_DEPTH):0] o_count
);

    localparam int C_AW = $clog2(C_DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_CW-1:0] C_FULL = C_CW'(C_DEPTH);

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_CW-1:0]    r_count;
    logic               w_wr;
    logic               w_rd;

    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr && !i_flush && (r_count != C_FULL);
    assign w_rd    = i_rd && !i_flush && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + C_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + C_AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pfu.sv
// Prefetch unit: issues word fetches, buffers in-order responses for decode, and handles redirects.
// Buffer space is reserved per outstanding request, so a response always finds a free entry.
module pfu
    import pfu_pkg::*;
#(
    parameter int                C_XLEN       = 32,
    parameter int                C_FIFO_DEPTH = 4,
    parameter logic [C_XLEN-1:0] C_RESET_VEC  = C_XLEN'(RESET_VEC)
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    output logic              pc_ready_o,
    input  logic              pc_wr_i,
    input  logic [C_XLEN-1:0] pc_i,
    pfu_if.master             bus
);

    localparam int C_AW = $clog2(C_FIFO_DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam int C_IW = C_CW + 1;
    localparam int C_EW = 1 + C_XLEN + C_INSN_W;
    localparam logic [C_IW-1:0] C_DEPTH_V = C_IW'(C_FIFO_DEPTH);

    logic              r_fetch_en;
    logic [C_XLEN-1:0] r_fetch_pc;
    logic [C_XLEN-1:0] r_rsp_pc;
    logic [C_CW-1:0]   r_outstanding;
    logic [C_CW-1:0]   r_discard_cnt;

    logic [C_CW-1:0]   w_fifo_count;
    logic [C_IW-1:0]   w_inflight;
    logic [C_CW-1:0]   w_outst_next;
    logic              w_req_valid;
    logic              w_req_xfer;
    logic              w_redirect;
    logic              w_rsp_keep;
    logic              w_rsp_drop;
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic              w_fifo_empty;
    logic [C_EW-1:0]   w_wdata;
    logic [C_EW-1:0]   w_rdata;
    logic [C_XLEN-1:0] w_new_pc;

    // Entries already buffered plus responses still owed must leave room for one more.
    assign w_inflight   = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_req_valid  = r_fetch_en && (w_inflight < C_DEPTH_V);
    assign pc_ready_o   = !w_req_valid || bus.ireqready_i;

    assign w_req_xfer   = clk_en_i && w_req_valid && bus.ireqready_i;
    assign w_redirect   = clk_en_i && pc_wr_i && pc_ready_o;
    assign w_rsp_drop   = clk_en_i && bus.irspvalid_i && (r_discard_cnt != '0);
    assign w_rsp_keep   = clk_en_i && bus.irspvalid_i && (r_discard_cnt == '0);
    assign w_fifo_wr    = w_rsp_keep && !w_redirect;
    assign w_fifo_rd    = clk_en_i && bus.ids_ack_i && !w_fifo_empty && !w_redirect;
    assign w_outst_next = r_outstanding + C_CW'(w_req_xfer) - C_CW'(bus.irspvalid_i);
    assign w_new_pc     = pc_i & ~C_XLEN'(3);
    assign w_wdata      = {bus.irsprerr_i, r_rsp_pc, bus.irspdata_i};

    assign bus.ireqvalid_o = w_req_valid;
    assign bus.ireqaddr_o  = r_fetch_pc;
    assign bus.ids_dav_o   = !w_fifo_empty;
    assign bus.ids_ins_o   = w_rdata[C_INSN_W-1:0];
    assign bus.ids_pc_o    = w_rdata[C_INSN_W +: C_XLEN];
    assign bus.ids_ferr_o  = (bus_err_e'(w_rdata[C_EW-1]) == BUS_ERR);

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fetch_en    <= 1'b0;
            r_fetch_pc    <= C_RESET_VEC;
            r_rsp_pc      <= C_RESET_VEC;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else if (clk_en_i) begin
            r_fetch_en    <= 1'b1;
            r_outstanding <= w_outst_next;
            if (w_redirect) begin
                // Every response still owed after this edge belongs to the old stream.
                r_fetch_pc    <= w_new_pc;
                r_rsp_pc      <= w_new_pc;
                r_discard_cnt <= w_outst_next;
            end else begin
                if (w_req_xfer) r_fetch_pc    <= r_fetch_pc + C_XLEN'(4);
                if (w_rsp_keep) r_rsp_pc      <= r_rsp_pc + C_XLEN'(4);
                if (w_rsp_drop) r_discard_cnt <= r_discard_cnt - C_CW'(1);
            end
        end
    end

    pfu_fifo #(
        .C_DEPTH (C_FIFO_DEPTH),
        .C_WIDTH (C_EW)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (resetb_i),
        .i_flush (w_redirect),
        .i_wr    (w_fifo_wr),
        .i_wdata (w_wdata),
        .i_rd    (w_fifo_rd),
        .o_rdata (w_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_pfu.sv
// Scoreboard bench for the prefetch unit: a bus model issues in-order responses,
// expected decode entries are queued as responses are driven and compared at the head.
module tb_pfu;
    import pfu_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hC0DE_1234;

    typedef struct { logic [31:0] addr; int unsigned cyc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic err; } ent_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic        clk_en;
    logic        pc_ready;
    logic        pc_wr;
    logic [31:0] pc;

    pfu_if #(.C_XLEN(XLEN)) bus ();

    pfu #(
        .C_XLEN       (XLEN),
        .C_FIFO_DEPTH (DEPTH),
        .C_RESET_VEC  (RESET_VEC)
    ) dut (
        .clk_i      (clk),
        .resetb_i   (resetb),
        .clk_en_i   (clk_en),
        .pc_ready_o (pc_ready),
        .pc_wr_i    (pc_wr),
        .pc_i       (pc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    req_t        pend[$];
    ent_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] m_pc;
    bit          m_fetch_en;
    int unsigned cyc = 0;

    int          ready_mode, ack_mode, rsp_mode, en_mode;
    bit          rsp_en;
    int unsigned lat;
    bit          g_pc_wr;
    logic [31:0] g_pc_val;
    logic [31:0] err_addr;

    logic        s_valid, s_dav, s_ferr, s_pc_ready;
    logic [31:0] s_addr, s_pc, s_ins;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step();
        bit          rdy, ack, en, rsp, rsp_err, exp_valid, xfer, redir, ackd;
        logic [31:0] rsp_addr;
        req_t        r;
        ent_t        e;

        en  = pick(en_mode);
        rdy = pick(ready_mode);
        ack = pick(ack_mode);
        rsp = 1'b0;
        if (en && rsp_en && pend.size() > 0) begin
            if (cyc >= pend[0].cyc + lat) rsp = pick(rsp_mode);
        end

        clk_en          = en;
        bus.ireqready_i = rdy;
        bus.ids_ack_i   = ack;
        pc_wr           = g_pc_wr;
        pc              = g_pc_val;
        bus.irspvalid_i = rsp;
        rsp_addr        = 32'h0;
        rsp_err         = 1'b0;
        if (rsp) begin
            rsp_addr       = pend[0].addr;
            rsp_err        = (rsp_addr == err_addr);
            bus.irspdata_i = rsp_addr ^ KEY;
            bus.irsprerr_i = rsp_err;
        end else begin
            bus.irspdata_i = $urandom;
            bus.irsprerr_i = 1'($urandom_range(0, 1));
        end
        #1;

        s_valid    = bus.ireqvalid_o;
        s_addr     = bus.ireqaddr_o;
        s_dav      = bus.ids_dav_o;
        s_pc       = bus.ids_pc_o;
        s_ins      = bus.ids_ins_o;
        s_ferr     = bus.ids_ferr_o;
        s_pc_ready = pc_ready;

        exp_valid = m_fetch_en && (exp_q.size() + pend.size() < DEPTH);
        check("ireqvalid", s_valid, exp_valid);
        if (exp_valid) check("ireqaddr", s_addr, m_pc);
        check("pc_ready", s_pc_ready, !exp_valid || rdy);
        check("ids_dav", s_dav, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("ids_pc", s_pc, exp_q[0].pc);
            check("ids_ins", s_ins, exp_q[0].ins);
            check("ids_ferr", s_ferr, exp_q[0].err);
        end

        xfer  = en && exp_valid && rdy;
        redir = en && pc_wr && (!exp_valid || rdy);
        ackd  = en && ack && exp_q.size() != 0;

        if (ackd) void'(exp_q.pop_front());
        if (rsp) begin
            r = pend.pop_front();
            if (!r.stale && !redir) begin
                e.pc  = rsp_addr;
                e.ins = rsp_addr ^ KEY;
                e.err = rsp_err;
                exp_q.push_back(e);
            end
        end
        if (xfer) begin
            r.addr  = m_pc;
            r.cyc   = cyc;
            r.stale = 1'b0;
            pend.push_back(r);
            req_log.push_back(s_addr);
        end
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_q.delete();
            m_pc    = g_pc_val & ~32'h3;
            g_pc_wr = 1'b0;
        end else if (xfer) begin
            m_pc = m_pc + 32'h4;
        end
        if (en) m_fetch_en = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset asynchronously and releases it two cycles later.
    task automatic do_reset();
        resetb          = 1'b0;
        clk_en          = 1'b0;
        pc_wr           = 1'b0;
        bus.ireqready_i = 1'b0;
        bus.irspvalid_i = 1'b0;
        bus.ids_ack_i   = 1'b0;
        #1;
        check("rst_ireqvalid", bus.ireqvalid_o, 1'b0);
        check("rst_ids_dav", bus.ids_dav_o, 1'b0);
        check("rst_pc_ready", pc_ready, 1'b1);
        check("rst_ireqaddr", bus.ireqaddr_o, RESET_VEC);
        pend.delete();
        exp_q.delete();
        m_pc       = RESET_VEC;
        m_fetch_en = 1'b0;
        g_pc_wr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        resetb          = 1'b0;
        clk_en          = 1'b0;
        pc_wr           = 1'b0;
        pc              = 32'h0;
        bus.ireqready_i = 1'b0;
        bus.irspvalid_i = 1'b0;
        bus.irspdata_i  = 32'h0;
        bus.irsprerr_i  = 1'b0;
        bus.ids_ack_i   = 1'b0;
        g_pc_wr         = 1'b0;
        g_pc_val        = 32'h0;
        err_addr        = 32'h8;
        en_mode = 1; ready_mode = 1; ack_mode = 0; rsp_mode = 1; rsp_en = 1'b1; lat = 1;

        @(negedge clk);
        do_reset();

        // Straight-line fetch with no decode acks fills the buffer.
        req_log.delete();
        repeat (8) step();
        for (int i = 0; i < 4; i++)
            check("fill_addr", (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
        check("fill_req_count", req_log.size(), 4);
        check("fill_valid_low", s_valid, 1'b0);
        check("fill_dav", s_dav, 1'b1);
        check("fill_head_pc", s_pc, 32'h0);

        // Drain with the bus stalled; only the 0x8 entry carries the error.
        ready_mode = 0; ack_mode = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_dav) check("ferr_tag", s_ferr, s_pc == 32'h8);
        end
        err_addr = 32'h3;

        // Redirect request while the bus stalls a valid request is held off.
        g_pc_wr = 1'b1; g_pc_val = 32'h200;
        repeat (3) step();
        check("stall_pc_ready", s_pc_ready, 1'b0);
        check("stall_valid", s_valid, 1'b1);
        check("stall_addr", s_addr, 32'h10);
        ready_mode = 1;
        step();
        step();
        check("stall_redir_addr", s_addr, 32'h200);

        ready_mode = 0; ack_mode = 1;
        repeat (8) step();

        // Three requests in flight at the redirect; their responses must be dropped.
        rsp_en = 1'b0; ready_mode = 1; ack_mode = 0;
        repeat (2) step();
        g_pc_wr = 1'b1; g_pc_val = 32'h103;
        step();
        rsp_en = 1'b1;
        step();
        check("drop_valid", s_valid, 1'b1);
        check("drop_addr", s_addr, 32'h100);
        for (int i = 0; i < 20 && !s_dav; i++) step();
        check("drop_dav", s_dav, 1'b1);
        check("drop_head_pc", s_pc, 32'h100);

        // Fetch address wraps past the top of the address space.
        ack_mode = 1;
        g_pc_wr = 1'b1; g_pc_val = 32'hFFFF_FFFC;
        step();
        step();
        for (int i = 0; i < 20 && !s_valid; i++) step();
        check("wrap_valid", s_valid, 1'b1);
        check("wrap_hi", s_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_lo", s_addr, 32'h0);

        // Response, ack and redirect land in the same cycle.
        repeat (10) step();
        g_pc_wr = 1'b1; g_pc_val = 32'h400;
        step();
        check("same_cyc_dav", s_dav, 1'b1);
        check("same_cyc_pc_ready", s_pc_ready, 1'b1);
        step();
        check("same_cyc_flush", s_dav, 1'b0);
        check("same_cyc_addr", s_addr, 32'h400);

        // Random traffic with clock-enable gaps, stalls, jittered responses and redirects.
        en_mode = 2; ready_mode = 2; ack_mode = 2; rsp_mode = 2;
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 1500; i++) begin
                if (i % 300 == 0) lat = $urandom_range(1, 3);
                if (!g_pc_wr && $urandom_range(0, 40) == 0) begin
                    g_pc_wr  = 1'b1;
                    g_pc_val = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                           : $urandom;
                end
                step();
            end
            do_reset();
        end
        repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pfu.md
PFU -- requirements
Module: pfu

Interface
REQ-001 Parameter C_XLEN, default 32: datapath and address width.
REQ-002 Parameter C_FIFO_DEPTH, default 4: instruction buffer entries, power of two and at least 2.
REQ-003 Parameter C_RESET_VEC, default 32'h0000_0000: first fetch address after reset.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 resetb_i  in  1  asynchronous active-low reset.
REQ-006 clk_en_i  in  1  global clock enable; no state changes while low.
REQ-007 pc_ready_o  out  1  a PC write will be accepted this cycle.
REQ-008 pc_wr_i  in  1  redirect request from the vectoring block.
REQ-009 pc_i  in  C_XLEN  redirect target.
REQ-010 ireqready_i  in  1  instruction bus accepts the request.
REQ-011 ireqvalid_o  out  1  fetch request valid.
REQ-012 ireqaddr_o  out  C_XLEN  fetch address, word aligned.
REQ-013 irspvalid_i  in  1  fetch response valid.
REQ-014 irspdata_i  in  32  fetched instruction word.
REQ-015 irsprerr_i  in  1  bus error on this response.
REQ-016 ids_dav_o  out  1  an instruction is available to decode.
REQ-017 ids_ack_i  in  1  decoder consumes the head entry.
REQ-018 ids_ins_o  out  32  head instruction.
REQ-019 ids_pc_o  out  C_XLEN  head instruction address.
REQ-020 ids_ferr_o  out  1  head entry carries a fetch error.

Function
REQ-021 Fetch-request handshake: a request transfers on a cycle with ireqvalid_o and ireqready_i both high and clk_en_i high.
REQ-022 Once ireqvalid_o is asserted, it and ireqaddr_o hold until the request transfers or a redirect occurs.
REQ-023 Registered fetch_en_q is 0 in reset, becomes 1 on the first enabled clock, and gates ireqvalid_o.
REQ-024 ireqvalid_o = fetch_en_q AND (fifo_count + outstanding < C_FIFO_DEPTH), so buffer space is reserved for every outstanding response.
REQ-025 On each transferred request the fetch PC advances by 4, modulo 2^C_XLEN (wrap-around is allowed).
REQ-026 Bus responses return in order, at the earliest one cycle after the request transfers.
REQ-027 The outstanding counter is incremented by a transferred request, decremented by a response, and unchanged when both happen in the same cycle.
REQ-028 pc_ready_o = NOT ireqvalid_o OR ireqready_i, computed combinationally.
REQ-029 Redirect: a redirect occurs when pc_wr_i and pc_ready_o are both high.
   - The fetch PC is loaded with pc_i with bits [1:0] cleared.
   - The FIFO is flushed.
   - discard_cnt is loaded with outstanding + req_xfer - rsp_valid, all evaluated in that cycle.
REQ-030 While discard_cnt is nonzero, each response decrements it and is dropped, not written to the FIFO.
REQ-031 A response not discarded writes {irsprerr_i, response PC, irspdata_i} into the FIFO. The response PC comes from a separate in-order response-PC counter, reloaded at redirect.
REQ-032 A fetch error does not stop fetching; the error entry is delivered in order.
REQ-033 ids_dav_o = FIFO not empty. ids_ins_o, ids_pc_o and ids_ferr_o show the head entry with no added latency.
REQ-034 An ack when ids_dav_o is low is ignored.
REQ-035 A FIFO write and an ack in the same cycle leave the count unchanged.
REQ-036 A redirect takes priority over an ack, a write and a request in the same cycle. Next cycle ids_dav_o = 0, and ireqaddr_o = new PC if space allows.
REQ-037 Latency: a response received at cycle N with an empty FIFO raises ids_dav_o at cycle N+1.

Reset
REQ-038 Reset values:
   - ireqvalid_o = 0, ids_dav_o = 0, pc_ready_o = 1
   - fetch PC = C_RESET_VEC
   - FIFO empty; outstanding, discard_cnt and fetch_en_q all 0
REQ-039 Reset asserted mid-operation returns the block to the REQ-038 state immediately. Responses arriving after reset for pre-reset requests are the bus's responsibility to suppress.

Structure
REQ-040 C_RESET_VEC, the instruction width and the bus error encoding live in the shared core constants package, used by both this block and the vectoring block.
REQ-041 The instruction buffer is one sub-module, pfu_fifo: synchronous FIFO, parameterised depth and width, flush input, count output, asynchronous reset.

Verification
REQ-042 Reset release, ireqready_i=1, one-cycle response latency: requests go to 0x0, 0x4, 0x8, 0xC; then ireqvalid_o drops with the FIFO full; ids_pc_o=0x0.
REQ-043 ireqready_i held low: pc_ready_o=0 and ireqaddr_o is stable; pc_wr_i is ignored until ireqready_i rises.
REQ-044 Three outstanding requests, then redirect pc_i=0x103: next ireqaddr_o=0x100; three responses dropped; first ids_pc_o=0x100.
REQ-045 Response with irsprerr_i=1 at 0x8: ids_ferr_o=1 only for the 0x8 entry; fetch continues at 0xC onward.
REQ-046 Fetch PC at 0xFFFF_FFFC accepted: next ireqaddr_o=0x0.
REQ-047 Response, ack and pc_wr_i all in the same cycle: FIFO empty next cycle, and that response is not delivered.
